ibus_responder: RTL and testbench
=================================

# ibus_responder

Instruction-bus responder: the memory-side end of the `ibus_req_t` / `ibus_resp_t` interface that the fetch stage drives. It accepts one fetch request at a time and returns the addressed 32-bit word from an internal word array after a fixed, parameterized latency. It flags out-of-range or misaligned fetches. It has a backdoor load port so benches and simulation top-levels can preload a program. It sits below the CPU core in simulation and FPGA builds, in place of a real instruction memory or cache.

## Interface
Parameters:
- `BASE`, 32'hbfc0_0000: byte address of word 0.
- `DEPTH`, 1024: number of 32-bit words; power of two, 16..65536.
- `LATENCY`, 2: cycles from acceptance to `data_ok`; range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ireq`  in  `ibus_req_t`  fetch request (`valid`, `addr`).
- `iresp`  out  `ibus_resp_t`  response (`addr_ok`, `data_ok`, `data`).
- `ld_en`  in  1  backdoor write enable.
- `ld_idx`  in  $clog2(DEPTH)  backdoor word index.
- `ld_data`  in  32  backdoor write data.
- `err`  out  1  pulses with `data_ok` when the served fetch was out of range or misaligned.
- `served`  out  32  count of completed responses; wraps modulo 2^32.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: one request accepted and awaiting its response.
- `iresp.addr_ok` is combinational: 1 in IDLE, and 1 in BUSY during the cycle that `data_ok` is 1; otherwise 0. It does not depend on `ireq.valid`.
- A request is accepted on a rising edge where `ireq.valid & iresp.addr_ok`.
- On acceptance:
  - latch `addr`;
  - load the down-counter with `LATENCY-1`;
  - enter BUSY (this also applies when already in BUSY, i.e. back-to-back).
- In BUSY the counter decrements each cycle. `data_ok` is 1 in the BUSY cycle where the counter is 0.
- On a `data_ok` cycle with no new acceptance, return to IDLE.
- Range and alignment check on the latched address: `off = addr - BASE` (32-bit, wrapping).
  - The fetch is valid iff `off < DEPTH*4` and `addr[1:0] == 0`.
  - Word index = `off[$clog2(DEPTH)+1:2]`.
- `iresp.data`:
  - valid fetch: array word at the latched index, read combinationally during the `data_ok` cycle;
  - invalid fetch: 32'h0000_0000 (NOP), with `err` = 1.
  - When `data_ok` is 0, `iresp.data` is 32'h0.
- Backdoor load: when `ld_en` = 1, `mem[ld_idx] <= ld_data` at the edge. It is allowed in any state.
- `served` increments by 1 at every edge where `data_ok` = 1.
- A request dropped by the initiator (`valid` falls before acceptance) leaves no state. After acceptance, `valid` is ignored until the response.

## Timing
- Reset values (asynchronous, held while `reset` = 1):
  - state IDLE, counter 0, latched addr 0;
  - `data_ok` 0, `data` 0, `err` 0, `served` 0;
  - `addr_ok` 1 once `reset` = 0.
  - Array contents are not reset.
- Latency: accepted at edge T → `data_ok` high during cycle T+LATENCY, for exactly one cycle.
- Throughput: one word per `LATENCY` cycles. `addr_ok` overlaps the `data_ok` cycle, so there are no bubbles.
- Read/write collision:
  - A backdoor write to the pending index at any edge before the `data_ok` cycle is visible in the response.
  - A write at the edge ending the `data_ok` cycle is not visible (old value returned).
- Reset asserted in BUSY: the pending response is discarded. No `data_ok` follows, and `served` is cleared.
- Address arithmetic wraps: an `addr` below `BASE` yields a large `off` → `err`.
- With `LATENCY` = 1 and `valid` held high: `data_ok` and `addr_ok` are high every cycle after the first acceptance.

## Test plan
- Preload `mem[0..3]` = 32'h1111_1111..32'h4444_4444 via `ld_*`. With LATENCY=2, request `addr` = 32'hbfc0_0004 → `addr_ok` 1 at acceptance; `data_ok` exactly 2 cycles later with `data` = 32'h2222_2222, `err` = 0, `served` = 1.
- Hold `valid` high with `addr` stepping +4 each acceptance from 32'hbfc0_0000, LATENCY=1 → data 32'h1111_1111, 2222_2222, 3333_3333, 4444_4444 on consecutive cycles; `served` = 4.
- Request 32'hbfc0_0002, then 32'hbfc0_0000 + DEPTH*4, then 32'hbfbf_fffc → each returns `data` = 32'h0 with `err` = 1 on its `data_ok` cycle.
- Accept 32'hbfc0_0008 with LATENCY=3; `ld_en` writes index 2 := 32'hdead_beef one cycle after acceptance → response is 32'hdead_beef. Repeat with the write at the edge ending the `data_ok` cycle → response 32'h3333_3333.
- Accept a request with LATENCY=4, assert `reset` 2 cycles later for 1 cycle → no `data_ok` ever appears, `served` = 0, and `addr_ok` = 1 the cycle after reset deasserts.
- Drive `valid` = 0 for 10 cycles from IDLE → `data_ok` stays 0, `addr_ok` stays 1, `served` unchanged.

Source files
------------

// File: rtl/ibus_responder.sv
// Memory-side responder for the instruction fetch bus: one outstanding fetch,
// fixed-latency response from an internal word array with a backdoor load port.
//
// Bus vectors (packed in field order, first field is the MSB):
//   ireq  = {valid, addr[31:0]}
//   iresp = {addr_ok, data_ok, data[31:0]}
//
// state | meaning
// ------+------------------------------------------
// IDLE  | no request outstanding
// BUSY  | one request accepted, awaiting its response
module ibus_responder #(
  parameter logic [31:0] BASE    = 32'hbfc0_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [32:0]                ireq,
  output logic [33:0]                iresp,
  input  logic                       ld_en,
  input  logic [$clog2(DEPTH)-1:0]   ld_idx,
  input  logic [31:0]                ld_data,
  output logic                       err,
  output logic [31:0]                served
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] SPAN   = 32'(DEPTH * 4);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] mem [DEPTH];

  logic        req_valid;
  logic [31:0] req_addr;
  logic        addr_ok;
  logic        data_ok;
  logic        accept;
  logic [31:0] off;
  logic        fetch_ok;
  logic [AW-1:0] idx;
  logic [31:0] data;

  assign req_valid = ireq[32];
  assign req_addr  = ireq[31:0];

  assign data_ok = (state == BUSY) && (cnt == 4'd0);
  assign addr_ok = (state == IDLE) || data_ok;
  assign accept  = req_valid && addr_ok;

  // Offset wraps, so addresses below BASE land far out of range.
  assign off      = addr_q - BASE;
  assign fetch_ok = (off < SPAN) && (addr_q[1:0] == 2'b00);
  assign idx      = off[AW+1:2];

  always_comb begin
    data = 32'h0000_0000;
    if (data_ok && fetch_ok) begin
      data = mem[idx];
    end
  end

  assign err   = data_ok && !fetch_ok;
  assign iresp = {addr_ok, data_ok, data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= 32'h0000_0000;
      served <= 32'h0000_0000;
    end else begin
      if (data_ok) begin
        served <= served + 32'd1;
      end
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= LAT_M1;
        state  <= BUSY;
      end else if (state == BUSY) begin
        if (data_ok) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // Array contents survive reset; a write at the edge ending data_ok is not seen.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ibus_responder.sv
// Bench for ibus_responder: four instances with LATENCY 1..4 driven by directed
// and randomized fetches, checked against a word-array reference model.
module tb_ibus_responder;

  localparam logic [31:0] BASE  = 32'hbfc0_0000;
  localparam int          DEPTH = 1024;
  localparam int          NPRE  = 32;

  logic clk;
  logic reset;
  logic [3:0][32:0] ireq;
  logic [3:0][33:0] iresp;
  logic [3:0]       ld_en;
  logic [3:0][9:0]  ld_idx;
  logic [3:0][31:0] ld_data;
  logic [3:0]       err;
  logic [3:0][31:0] served;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [4][DEPTH];
  logic [31:0] served_m [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ibus_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(g + 1)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .ireq    (ireq[g]),
      .iresp   (iresp[g]),
      .ld_en   (ld_en[g]),
      .ld_idx  (ld_idx[g]),
      .ld_data (ld_data[g]),
      .err     (err[g]),
      .served  (served[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [9:0] i, input logic [31:0] d);
    ld_en[k] = 1'b1; ld_idx[k] = i; ld_data[k] = d;
    step();
    ld_en[k] = 1'b0;
    mem_m[k][i] = d;
  endtask

  function automatic logic [31:0] expect_data(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off < 32'(DEPTH * 4) && a[1:0] == 2'b00) return mem_m[k][off[11:2]];
    return 32'h0;
  endfunction

  function automatic logic expect_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return !(off < 32'(DEPTH * 4) && a[1:0] == 2'b00);
  endfunction

  // One fetch on instance k (LATENCY k+1); optional backdoor write wr_at edges after acceptance.
  task automatic fetch(input int k, input logic [31:0] a, input int wr_at,
                       input logic [9:0] widx, input logic [31:0] wdat);
    int lat;
    lat = k + 1;
    ireq[k] = {1'b1, a};
    chk($sformatf("addr_ok_acc[%0d]", k), 32'(iresp[k][33]), 32'd1);
    step();
    ireq[k][32] = 1'b0;
    for (int e = 1; e <= lat; e++) begin
      chk($sformatf("data_ok[%0d] e%0d", k, e), 32'(iresp[k][32]), 32'(e == lat));
      chk($sformatf("addr_ok[%0d] e%0d", k, e), 32'(iresp[k][33]), 32'(e == lat));
      if (e == lat) begin
        chk($sformatf("data[%0d] a=%h", k, a), iresp[k][31:0], expect_data(k, a));
        chk($sformatf("err[%0d] a=%h", k, a), 32'(err[k]), 32'(expect_err(a)));
      end
      if (wr_at == e) begin
        ld_en[k] = 1'b1; ld_idx[k] = widx; ld_data[k] = wdat;
      end
      step();
      if (wr_at == e) begin
        ld_en[k] = 1'b0;
        mem_m[k][widx] = wdat;
      end
    end
    served_m[k]++;
    chk($sformatf("served[%0d]", k), served[k], served_m[k]);
    chk($sformatf("data_ok_after[%0d]", k), 32'(iresp[k][32]), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int k, kind, w;
    reset = 1'b1;
    ireq = '0; ld_en = '0; ld_idx = '0; ld_data = '0;
    for (int i = 0; i < 4; i++) served_m[i] = 32'd0;
    #12;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst data_ok[%0d]", i), 32'(iresp[i][32]), 32'd0);
      chk($sformatf("rst data[%0d]", i), iresp[i][31:0], 32'd0);
      chk($sformatf("rst err[%0d]", i), 32'(err[i]), 32'd0);
      chk($sformatf("rst served[%0d]", i), served[i], 32'd0);
    end
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) chk($sformatf("post_rst addr_ok[%0d]", i), 32'(iresp[i][33]), 32'd1);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < NPRE; j++) begin
        if (j < 4) load(i, 10'(j), 32'h1111_1111 * 32'(j + 1));
        else load(i, 10'(j), $urandom());
      end
    end

    fetch(1, 32'hbfc0_0004, 0, 10'd0, 32'h0);

    // LATENCY=1 streaming with valid held high
    ireq[0] = {1'b1, BASE};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stream data_ok %0d", i), 32'(iresp[0][32]), 32'd1);
      chk($sformatf("stream addr_ok %0d", i), 32'(iresp[0][33]), 32'd1);
      chk($sformatf("stream data %0d", i), iresp[0][31:0], 32'h1111_1111 * 32'(i + 1));
      served_m[0]++;
      if (i < 3) ireq[0] = {1'b1, BASE + 32'(4 * (i + 1))};
      else ireq[0][32] = 1'b0;
    end
    step();
    chk("stream served", served[0], served_m[0]);
    chk("stream served4", served[0], 32'd4);

    fetch(1, 32'hbfc0_0002, 0, 10'd0, 32'h0);
    fetch(1, BASE + 32'(DEPTH * 4), 0, 10'd0, 32'h0);
    fetch(1, 32'hbfbf_fffc, 0, 10'd0, 32'h0);

    fetch(2, 32'hbfc0_0008, 1, 10'd2, 32'hdead_beef);
    load(2, 10'd2, 32'h3333_3333);
    fetch(2, 32'hbfc0_0008, 3, 10'd2, 32'hdead_beef);
    load(2, 10'd2, 32'h3333_3333);

    // reset while BUSY discards the pending response
    ireq[3] = {1'b1, 32'hbfc0_000c};
    step();
    ireq[3][32] = 1'b0;
    step();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) served_m[i] = 32'd0;
    chk("rstbusy data_ok", 32'(iresp[3][32]), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rstbusy addr_ok", 32'(iresp[3][33]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rstbusy no data_ok %0d", c), 32'(iresp[3][32]), 32'd0);
      step();
    end
    chk("rstbusy served", served[3], 32'd0);

    for (int c = 0; c < 10; c++) begin
      chk($sformatf("idle data_ok %0d", c), 32'(iresp[1][32]), 32'd0);
      chk($sformatf("idle addr_ok %0d", c), 32'(iresp[1][33]), 32'd1);
      step();
    end
    chk("idle served", served[1], served_m[1]);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 3);
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, NPRE - 1));
        3:       a = BASE + 32'(4 * $urandom_range(0, NPRE - 1)) + 32'($urandom_range(1, 3));
        4:       a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 100000));
        default: a = BASE - 32'(4 * $urandom_range(1, 100000));
      endcase
      w = $urandom_range(0, k + 2);
      fetch(k, a, w, 10'($urandom_range(0, NPRE - 1)), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
